// File: rtl/piano_keypad_poly.sv
// piano_keypad_poly
// Polyphonic keypad decoder. Keypad press/release events are taken on the
// rising edge of 'ready'. Each held note key is allocated to one of CHANNELS
// voice slots. Each slot reports note and octave to the tone generators.
// Also handles a runtime base octave (up/down keys), all-notes-off, duplicate
// suppression and optional voice stealing.
//
// Ports
//   clk          in   1            system clock, rising edge
//   rst_n        in   1            asynchronous active-low reset
//   ready        in   1            keypad data valid; one event per rising edge
//   keycode      in   5            key index, sampled with ready
//   key_release  in   1            0 = press, 1 = release, sampled with ready
//   note         out  4*CHANNELS   slot i at [4i+3:4i]; 0 = rest, 1..12 = C..B
//   octave       out  4*CHANNELS   slot i at [4i+3:4i]
//   active       out  CHANNELS     slot i holds a key
//   base_octave  out  4            current base octave
//   event_ack    out  1            one-cycle pulse per accepted event
//   overflow     out  1            one-cycle pulse when a press found no free slot
module piano_keypad_poly #(
  parameter int CHANNELS       = 4,
  parameter int DEFAULT_OCTAVE = 4,
  parameter int MIN_OCTAVE     = 1,
  parameter int MAX_OCTAVE     = 7,
  parameter int STEAL          = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ready,
  input  logic [4:0]            keycode,
  input  logic                  key_release,
  output logic [4*CHANNELS-1:0] note,
  output logic [4*CHANNELS-1:0] octave,
  output logic [CHANNELS-1:0]   active,
  output logic [3:0]            base_octave,
  output logic                  event_ack,
  output logic                  overflow
);

  localparam int VW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic          ready_q;
  logic [4:0]    key_mem [CHANNELS];
  logic [VW-1:0] victim;

  logic                take;
  logic                is_note;
  logic [3:0]          dec_note;
  logic [3:0]          dec_oct;
  logic [3:0]          oct_up;
  logic [3:0]          oct_down;
  logic [CHANNELS-1:0] hit_vec;
  logic [CHANNELS-1:0] slot_set;
  logic [CHANNELS-1:0] slot_clr;
  logic                any_hit;
  logic                has_free;
  logic                press_full;

  // Event decode: find the held slot for this key, the lowest free slot, and
  // turn the event into per-slot set/clear enables.
  always_comb begin
    take     = ready & ~ready_q;
    is_note  = (keycode >= 5'd1) && (keycode <= 5'd24);
    oct_up   = (base_octave >= 4'(MAX_OCTAVE)) ? 4'(MAX_OCTAVE) : base_octave + 4'd1;
    oct_down = (base_octave <= 4'(MIN_OCTAVE)) ? 4'(MIN_OCTAVE) : base_octave - 4'd1;
    if (keycode > 5'd12) begin
      dec_note = 4'(keycode - 5'd12);
      dec_oct  = oct_up;
    end else begin
      dec_note = keycode[3:0];
      dec_oct  = base_octave;
    end

    hit_vec  = '0;
    slot_set = '0;
    slot_clr = '0;
    has_free = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      hit_vec[i] = active[i] && (key_mem[i] == keycode);
    end
    any_hit = |hit_vec;

    // Only the lowest-index idle slot is claimed.
    for (int i = 0; i < CHANNELS; i++) begin
      if (!active[i] && !has_free) begin
        has_free = 1'b1;
        if (take && is_note && !key_release && !any_hit) slot_set[i] = 1'b1;
      end
    end

    press_full = take && is_note && !key_release && !any_hit && !has_free;

    for (int i = 0; i < CHANNELS; i++) begin
      if (press_full && (STEAL != 0) && (victim == VW'(i))) slot_set[i] = 1'b1;
      if (take && is_note && key_release && hit_vec[i]) slot_clr[i] = 1'b1;
      if (take && !key_release && (keycode == 5'd27)) slot_clr[i] = 1'b1;
    end
  end

  // All state and outputs; every effect lands on the edge that sees the event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q     <= 1'b0;
      note        <= '0;
      octave      <= '0;
      active      <= '0;
      base_octave <= 4'(DEFAULT_OCTAVE);
      event_ack   <= 1'b0;
      overflow    <= 1'b0;
      victim      <= '0;
      for (int i = 0; i < CHANNELS; i++) key_mem[i] <= 5'd0;
    end else begin
      ready_q   <= ready;
      event_ack <= take;
      overflow  <= press_full;

      if (press_full && (STEAL != 0)) begin
        victim <= (victim == VW'(CHANNELS - 1)) ? '0 : victim + 1'b1;
      end

      if (take && !key_release) begin
        if (keycode == 5'd25) base_octave <= oct_down;
        if (keycode == 5'd26) base_octave <= oct_up;
      end

      // Octave is left untouched on clear so a released voice keeps its register.
      for (int i = 0; i < CHANNELS; i++) begin
        if (slot_set[i]) begin
          key_mem[i]       <= keycode;
          note[4*i +: 4]   <= dec_note;
          octave[4*i +: 4] <= dec_oct;
          active[i]        <= 1'b1;
        end else if (slot_clr[i]) begin
          note[4*i +: 4] <= 4'd0;
          active[i]      <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_piano_keypad_poly.sv
// tb_piano_keypad_poly
// Drives two decoders (STEAL=0 and STEAL=1) from the same keypad stream and
// compares every output against a slot-table model of the keypad rules.
module tb_piano_keypad_poly;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        ready;
  logic [4:0]  keycode;
  logic        key_release;
  logic [15:0] note0, oct0, note1, oct1;
  logic [3:0]  act0, act1, base0, base1;
  logic        ack0, ack1, ovf0, ovf1;

  piano_keypad_poly #(.CHANNELS(4), .STEAL(0)) dut (
    .clk(clk), .rst_n(rst_n), .ready(ready), .keycode(keycode),
    .key_release(key_release), .note(note0), .octave(oct0), .active(act0),
    .base_octave(base0), .event_ack(ack0), .overflow(ovf0)
  );

  piano_keypad_poly #(.CHANNELS(4), .STEAL(1)) dut_steal (
    .clk(clk), .rst_n(rst_n), .ready(ready), .keycode(keycode),
    .key_release(key_release), .note(note1), .octave(oct1), .active(act1),
    .base_octave(base1), .event_ack(ack1), .overflow(ovf1)
  );

  int vectors = 0;
  int errors  = 0;

  // Reference slot table, index 0 = no stealing, 1 = stealing.
  int m_note [2][4];
  int m_oct  [2][4];
  int m_act  [2][4];
  int m_key  [2][4];
  int m_base [2];
  int m_vic  [2];

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) begin
        m_note[d][i] = 0; m_oct[d][i] = 0; m_act[d][i] = 0; m_key[d][i] = 0;
      end
      m_base[d] = 4;
      m_vic[d]  = 0;
    end
  endtask

  task automatic modelPlace(input int d, input int s, input int code, input int n, input int o);
    m_key[d][s] = code; m_note[d][s] = n; m_oct[d][s] = o; m_act[d][s] = 1;
  endtask

  // Applies one keypad event to the table; returns the expected overflow pulse.
  task automatic modelEvent(input int d, input int code, input int rel, output int ovf);
    int hit, free, n, o;
    ovf = 0; hit = -1; free = -1;
    for (int i = 0; i < 4; i++) begin
      if (m_act[d][i] != 0 && m_key[d][i] == code && hit < 0) hit = i;
      if (m_act[d][i] == 0 && free < 0) free = i;
    end
    if (code >= 1 && code <= 24) begin
      n = (code > 12) ? code - 12 : code;
      o = (code > 12) ? ((m_base[d] + 1 > 7) ? 7 : m_base[d] + 1) : m_base[d];
      if (rel != 0) begin
        if (hit >= 0) begin
          m_act[d][hit] = 0; m_note[d][hit] = 0;
        end
      end else if (hit < 0) begin
        if (free >= 0) modelPlace(d, free, code, n, o);
        else begin
          ovf = 1;
          if (d == 1) begin
            modelPlace(d, m_vic[d], code, n, o);
            m_vic[d] = (m_vic[d] + 1) % 4;
          end
        end
      end
    end else if (rel == 0) begin
      if (code == 25) m_base[d] = (m_base[d] - 1 < 1) ? 1 : m_base[d] - 1;
      if (code == 26) m_base[d] = (m_base[d] + 1 > 7) ? 7 : m_base[d] + 1;
      if (code == 27) begin
        for (int i = 0; i < 4; i++) begin
          m_act[d][i] = 0; m_note[d][i] = 0;
        end
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkAll(input int ack_exp, input int ovf_e0, input int ovf_e1);
    logic [15:0] en [2];
    logic [15:0] eo [2];
    logic [3:0]  ea [2];
    for (int d = 0; d < 2; d++) begin
      en[d] = '0; eo[d] = '0; ea[d] = '0;
      for (int i = 0; i < 4; i++) begin
        en[d][4*i +: 4] = 4'(m_note[d][i]);
        eo[d][4*i +: 4] = 4'(m_oct[d][i]);
        ea[d][i]        = (m_act[d][i] != 0);
      end
    end
    checkOutput("note",         32'(note0), 32'(en[0]));
    checkOutput("octave",       32'(oct0),  32'(eo[0]));
    checkOutput("active",       32'(act0),  32'(ea[0]));
    checkOutput("base",         32'(base0), 32'(m_base[0]));
    checkOutput("ack",          32'(ack0),  32'(ack_exp));
    checkOutput("overflow",     32'(ovf0),  32'(ovf_e0));
    checkOutput("steal_note",   32'(note1), 32'(en[1]));
    checkOutput("steal_octave", 32'(oct1),  32'(eo[1]));
    checkOutput("steal_active", 32'(act1),  32'(ea[1]));
    checkOutput("steal_base",   32'(base1), 32'(m_base[1]));
    checkOutput("steal_ack",    32'(ack1),  32'(ack_exp));
    checkOutput("steal_ovf",    32'(ovf1),  32'(ovf_e1));
  endtask

  // One keypad event with ready held high for 'hold' cycles, then one low cycle.
  task automatic applyStimulus(input int code, input int rel, input int hold);
    int o0, o1;
    @(negedge clk);
    keycode = 5'(code); key_release = rel[0]; ready = 1'b1;
    modelEvent(0, code, rel, o0);
    modelEvent(1, code, rel, o1);
    @(posedge clk); #1;
    checkAll(1, o0, o1);
    for (int h = 1; h < hold; h++) begin
      @(posedge clk); #1;
      checkAll(0, 0, 0);
    end
    @(negedge clk);
    ready = 1'b0; keycode = 5'($urandom_range(0, 31)); key_release = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    checkAll(0, 0, 0);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    ready = 1'b0;
    rst_n = 1'b0;
    modelReset();
    #1 checkAll(0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1; ready = 1'b0; keycode = 5'd0; key_release = 1'b0;
    modelReset();
    #2 rst_n = 1'b0;
    #1 checkAll(0, 0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 checkAll(0, 0, 0);

    // ready held high over several cycles: one event only.
    applyStimulus(5, 0, 4);
    // Duplicate, upper-row note, release, then refill of the lowest slot.
    applyStimulus(5, 0, 1);
    applyStimulus(17, 0, 1);
    applyStimulus(5, 1, 1);
    applyStimulus(1, 0, 1);
    applyStimulus(0, 0, 1);
    applyStimulus(30, 0, 1);
    // Octave saturation at both ends while slots stay held.
    for (int k = 0; k < 4; k++) applyStimulus(26, 0, 1);
    applyStimulus(24, 0, 1);
    for (int k = 0; k < 7; k++) applyStimulus(25, 0, 1);
    applyStimulus(26, 1, 1);
    applyStimulus(12, 0, 1);

    // Full table: fifth press overflows (and steals in the second decoder).
    pulseReset();
    for (int k = 1; k <= 5; k++) applyStimulus(k, 0, 1);
    applyStimulus(6, 0, 1);
    applyStimulus(3, 1, 1);
    applyStimulus(7, 0, 1);

    // Reset landing in the middle of a held event.
    pulseReset();
    for (int k = 8; k <= 10; k++) applyStimulus(k, 0, 1);
    @(negedge clk);
    keycode = 5'd11; key_release = 1'b0; ready = 1'b1;
    #2 rst_n = 1'b0;
    modelReset();
    #1 checkAll(0, 0, 0);
    @(negedge clk);
    ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 8; k <= 10; k++) applyStimulus(k, 0, 1);
    applyStimulus(27, 0, 1);
    applyStimulus(27, 1, 1);

    // Random traffic, weighted toward note keys.
    for (int n = 0; n < 250; n++) begin
      int code, rel;
      if ($urandom_range(0, 9) < 7) code = $urandom_range(1, 24);
      else                          code = $urandom_range(0, 31);
      rel = ($urandom_range(0, 2) == 0) ? 1 : 0;
      applyStimulus(code, rel, $urandom_range(1, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
